alu_arith_arbiter: RTL and testbench

Round-robin arbiter and issue controller that shares one combinational arithmetic ALU (ADD, SUB, SEQ, SNE, SLT, SGT, SLE, SGE) between two requesters. It accepts operations over valid/ready handshakes, registers one operation per cycle into an issue stage that drives the ALU, and captures each result into a per-requester response FIFO. It sits between the integer issue logic (requester 0) and the address/branch-compare logic (requester 1) and the shared ALU.

---
 rtl/alu_arith_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arith_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arith_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arith_arbiter
// Description : Round-robin arbiter sharing one arithmetic ALU between two
//               requesters, with a one-deep issue stage and credit-managed
//               per-requester response FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arith_arbiter #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [5:0]            req_op,
    input  logic [2*TAG_W-1:0]    req_tag,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic [2*TAG_W-1:0]    rsp_tag,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    output logic [2:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_out
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

    logic              issue_valid_q, issue_valid_d;
    logic              issue_owner_q, issue_owner_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d;
    logic [DATA_W-1:0] issue_b_q, issue_b_d;
    logic [2:0]        issue_op_q, issue_op_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        eligible;
    logic [1:0]        grant;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (eligible[0] && (!eligible[1] || last_grant_q)) begin
                grant[0] = 1'b1;
            end else if (eligible[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        issue_valid_d = |grant;
        issue_owner_d = issue_owner_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_op_d    = issue_op_q;
        issue_tag_d   = issue_tag_q;
        last_grant_d  = last_grant_q;
        if (|grant) begin
            issue_owner_d = grant[1];
            last_grant_d  = grant[1];
            issue_a_d     = grant[1] ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            issue_b_d     = grant[1] ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            issue_op_d    = grant[1] ? req_op[5:3] : req_op[2:0];
            issue_tag_d   = grant[1] ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_owner_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_op_q    <= '0;
            issue_tag_q   <= '0;
            last_grant_q  <= 1'b1;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_owner_q <= issue_owner_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_op_q    <= issue_op_d;
            issue_tag_q   <= issue_tag_d;
            last_grant_q  <= last_grant_d;
        end
    end

    // Operands hold while the issue stage is idle.
    assign alu_in1 = issue_a_q;
    assign alu_in2 = issue_b_q;
    assign alu_op  = issue_op_q;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        logic [DATA_W-1:0] data_q [RSP_DEPTH];
        logic [DATA_W-1:0] data_d [RSP_DEPTH];
        logic [TAG_W-1:0]  tag_q  [RSP_DEPTH];
        logic [TAG_W-1:0]  tag_d  [RSP_DEPTH];
        logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              push, pop;
        logic [CNT_W:0]    occupancy;

        assign push      = issue_valid_q && (issue_owner_q == 1'(g));
        assign pop       = rsp_ready[g] && (cnt_q != '0);
        // Credit counts the in-flight issue entry, so a push never overflows.
        assign occupancy = {1'b0, cnt_q} + {{CNT_W{1'b0}}, push};
        assign eligible[g] = req_valid[g] && (occupancy < DEPTH_C);

        always_comb begin
            data_d = data_q;
            tag_d  = tag_q;
            wr_d   = wr_q;
            rd_d   = rd_q;
            cnt_d  = cnt_q;
            if (push) begin
                data_d[wr_q] = alu_out;
                tag_d[wr_q]  = issue_tag_q;
                wr_d = (wr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = (rd_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
            end
            data_q <= data_d;
            tag_q  <= tag_d;
        end

        assign rsp_valid[g]                   = (cnt_q != '0);
        assign rsp_data[g*DATA_W +: DATA_W]   = data_q[rd_q];
        assign rsp_tag[g*TAG_W +: TAG_W]      = tag_q[rd_q];
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arith_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arith_arbiter
// Description : Directed self-checking bench with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arith_arbiter;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 4;
    localparam int RSP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0]   req_a, req_b, rsp_data;
    logic [5:0]    req_op;
    logic [7:0]    req_tag, rsp_tag;
    logic [31:0]   alu_in1, alu_in2, alu_out;
    logic [2:0]    alu_op;

    rsp_t          sb0[$], sb1[$];
    rsp_t          exp0, exp1;
    int            errors = 0;
    int            checks = 0;
    int            seq0 = 0, seq1 = 0;

    always #5 clk = ~clk;

    alu_arith_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return {31'd0, a == b};
            3'd3:    return {31'd0, a != b};
            3'd4:    return {31'd0, $signed(a) <  $signed(b)};
            3'd5:    return {31'd0, $signed(a) >  $signed(b)};
            3'd6:    return {31'd0, $signed(a) <= $signed(b)};
            default: return {31'd0, $signed(a) >= $signed(b)};
        endcase
    endfunction

    assign alu_out = alu_model(alu_in1, alu_in2, alu_op);

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on each response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (req_valid[0] && req_ready[0]) sb0.push_back(exp0);
            if (req_valid[1] && req_ready[1]) sb1.push_back(exp1);
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (sb0.size() == 0) chk("rsp0_unexpected", 64'(sb0.size()), 64'd1);
                else begin
                    e = sb0.pop_front();
                    chk("rsp0_data", {32'd0, rsp_data[31:0]}, {32'd0, e.d});
                    chk("rsp0_tag", {60'd0, rsp_tag[3:0]}, {60'd0, e.t});
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (sb1.size() == 0) chk("rsp1_unexpected", 64'(sb1.size()), 64'd1);
                else begin
                    e = sb1.pop_front();
                    chk("rsp1_data", {32'd0, rsp_data[63:32]}, {32'd0, e.d});
                    chk("rsp1_tag", {60'd0, rsp_tag[7:4]}, {60'd0, e.t});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [3:0] tag, input logic [31:0] ed);
        if (i == 0) begin
            req_a[31:0] = a; req_b[31:0] = b; req_op[2:0] = op; req_tag[3:0] = tag;
            exp0 = '{d: ed, t: tag};
            req_valid[0] = 1'b1;
        end else begin
            req_a[63:32] = a; req_b[63:32] = b; req_op[5:3] = op; req_tag[7:4] = tag;
            exp1 = '{d: ed, t: tag};
            req_valid[1] = 1'b1;
        end
    endtask

    task automatic wait_accept(input int i, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req_valid[i] && req_ready[i];
            cyc();
        end
        chk(name, {63'd0, got}, 64'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic next_req(input int i);
        if (i == 0) begin
            set_req(0, 32'(seq0), 32'd100, 3'd0, 4'(seq0), 32'(seq0 + 100));
            seq0++;
        end else begin
            set_req(1, 32'd1000, 32'(seq1), 3'd1, 4'(seq1), 32'(1000 - seq1));
            seq1++;
        end
    endtask

    task automatic run_cycle(output logic [1:0] acc);
        @(negedge clk);
        acc = req_valid & req_ready;
        cyc();
        if (acc[0]) next_req(0);
        if (acc[1]) next_req(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ta[8], tb_v[8], te[8];
        logic [2:0]  to[8];
        logic [1:0]  acc;
        int          n0, n1;

        ta   = '{32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h7FFFFFFF, 32'd5, 32'd5, 32'd9, 32'd9};
        tb_v = '{32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd5, 32'd6, 32'd9, 32'd9};
        to   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
        te   = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0};

        reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        exp0 = '0; exp1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_alu_in1", {32'd0, alu_in1}, 64'd0);
        chk("rst_alu_in2", {32'd0, alu_in2}, 64'd0);
        chk("rst_alu_op", {61'd0, alu_op}, 64'd0);
        cyc();
        req_valid = 2'b00; reset = 1'b0;
        cyc();

        // Single op and latency.
        set_req(0, 32'd5, 32'd7, 3'd0, 4'd3, 32'd12);
        wait_accept(0, "single_accept");
        @(negedge clk);
        chk("lat_issue_only", {62'd0, rsp_valid}, 64'd0);
        chk("issue_in1", {32'd0, alu_in1}, 64'd5);
        chk("issue_in2", {32'd0, alu_in2}, 64'd7);
        @(negedge clk);
        chk("lat_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        cyc();

        // Arithmetic and compare boundaries.
        for (int j = 0; j < 8; j++) begin
            set_req(0, ta[j], tb_v[j], to[j], 4'(j), te[j]);
            wait_accept(0, "bnd_accept");
        end
        repeat (4) cyc();
        chk("bnd_drain", 64'(sb0.size()), 64'd0);

        // One r1 op so the next tie starts with r0.
        set_req(1, 32'd10, 32'd3, 3'd1, 4'd5, 32'd7);
        wait_accept(1, "r1_accept");
        repeat (4) cyc();

        // Tie fairness.
        next_req(0); next_req(1);
        for (int k = 0; k < 8; k++) begin
            run_cycle(acc);
            chk("tie_grant", {62'd0, acc}, (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        req_valid = 2'b00;
        repeat (5) cyc();
        chk("tie_drain", 64'(sb0.size() + sb1.size()), 64'd0);

        // Backpressure on r1.
        rsp_ready = 2'b01; n0 = 0; n1 = 0;
        next_req(0); next_req(1);
        for (int k = 0; k < 12; k++) begin
            run_cycle(acc);
            n0 += int'(acc[0]);
            n1 += int'(acc[1]);
        end
        chk("bp_r1_count", 64'(n1), 64'd2);
        chk("bp_r0_served", {63'd0, n0 >= 4}, 64'd1);
        @(negedge clk);
        chk("bp_r1_blocked", {63'd0, req_ready[1]}, 64'd0);
        cyc();
        req_valid[0] = 1'b0;
        rsp_ready[1] = 1'b1;
        cyc();
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp_resume", {63'd0, req_ready[1]}, 64'd1);
        cyc();
        req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (6) cyc();
        chk("bp_drain", 64'(sb0.size() + sb1.size()), 64'd0);

        // Hold stability, then simultaneous push and pop on FIFO0.
        rsp_ready = 2'b10;
        set_req(0, 32'd20, 32'd22, 3'd0, 4'hA, 32'd42);
        wait_accept(0, "pp_first");
        @(negedge clk);
        @(negedge clk);
        chk("hold_valid", {63'd0, rsp_valid[0]}, 64'd1);
        chk("hold_data_a", {32'd0, rsp_data[31:0]}, 64'd42);
        @(negedge clk);
        chk("hold_data_b", {32'd0, rsp_data[31:0]}, 64'd42);
        chk("hold_tag", {60'd0, rsp_tag[3:0]}, 64'hA);
        cyc();
        set_req(0, 32'd3, 32'd4, 3'd1, 4'hB, 32'hFFFFFFFF);
        wait_accept(0, "pp_second");
        rsp_ready[0] = 1'b1;
        cyc();
        @(negedge clk);
        chk("pp_still_one", {63'd0, rsp_valid[0]}, 64'd1);
        chk("pp_data", {32'd0, rsp_data[31:0]}, 64'hFFFFFFFF);
        cyc();
        @(negedge clk);
        chk("pp_empty", {63'd0, rsp_valid[0]}, 64'd0);
        cyc();

        // Reset mid-flight.
        rsp_ready = 2'b00;
        next_req(0); next_req(1);
        repeat (3) run_cycle(acc);
        @(negedge clk);
        chk("pre_rst_valid", {62'd0, rsp_valid}, 64'd3);
        cyc();
        reset = 1'b1;
        cyc();
        sb0.delete(); sb1.delete();
        @(negedge clk);
        chk("mid_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("mid_rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("mid_rst_alu_in1", {32'd0, alu_in1}, 64'd0);
        cyc();
        reset = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("post_rst_tie", {62'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 2'b00;
        repeat (5) cyc();
        chk("final_drain", 64'(sb0.size() + sb1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
